play_core: RTL and testbench
============================

// Module: play_core
// PURPOSE
//  Playback engine; counterpart of the recorder. Reads 32-bit words that the recorder stored in SDRAM
//  over [start_addr, end_addr) and unpacks each into two 16-bit samples. Streams the samples to the
//  audio DAC path via valid/ready. Prefetches words into a small FIFO so SDRAM latency never starves audio.
// PARAMETERS
//  ADDR_W      23  SDRAM word-address width
//  FIFO_DEPTH  4   prefetch FIFO depth in 32-bit words; power of 2, >=2
// PORTS
//  i_clk               in   1       system clock; single clock domain
//  i_rst               in   1       asynchronous, active-high reset
//  play_start          in   1       1-cycle pulse; start playback (ignored unless IDLE)
//  play_start_addr     in   ADDR_W  first word address; sampled on accepted start
//  play_end_addr       in   ADDR_W  end address, exclusive; sampled on accepted start
//  play_loop           in   1       1: wrap to start_addr at end; sampled on accepted start
//  play_pause          in   1       level; while 1 no new reads and no sample output
//  play_stop           in   1       1-cycle pulse; abort playback
//  play_done           out  1       1-cycle pulse; playback finished or aborted
//  play_read           out  1       SDRAM read request
//  play_addr           out  ADDR_W  SDRAM read address
//  play_readdata       in   32      SDRAM read data; valid when play_sdram_finished=1
//  play_sdram_finished in   1       1-cycle pulse; completes the current read
//  play_audio_data     out  16      sample to DAC path
//  play_audio_valid    out  1       play_audio_data is valid
//  play_audio_ready    in   1       DAC path accepts the sample
// BEHAVIOUR
//  Reset (async): state=IDLE; FIFO empty; half=0.
//    Outputs play_done, play_read, play_audio_valid = 0; play_addr = 0; play_audio_data = 0.
//  Fetch FSM states: IDLE, REQ, WAIT, PAUSED, DRAIN, ABORT.
//   IDLE: on play_start, latch start/end/loop and set cur=start.
//     If start==end, pulse play_done the next cycle and stay IDLE. Otherwise go to REQ.
//   REQ: when FIFO has a free slot and pause=0, assert play_read with play_addr=cur (registered) and go to WAIT.
//     If pause=1, go to PAUSED instead.
//   WAIT: play_read and play_addr held stable until play_sdram_finished.
//     That cycle: push play_readdata into the FIFO, drop play_read on the next cycle, cur=cur+1.
//     If new cur==end: with loop=1, cur=start and go to REQ; with loop=0, go to DRAIN.
//     Otherwise go to REQ. play_read is never high on two back-to-back requests without a 1-cycle gap.
//   PAUSED: no reads issued and play_audio_valid=0. On pause=0, return to REQ.
//     A read already in WAIT completes normally before pause takes effect.
//   DRAIN: no reads issued. When the FIFO is empty and no sample is pending, pulse play_done and go to IDLE.
//   ABORT (on play_stop in any non-IDLE state): if a read is in WAIT, hold play_read until finished
//     and discard the data. Then flush the FIFO, set half=0, pulse play_done, go to IDLE.
//     Stop has priority over pause and end-of-range in the same cycle.
//  Output side:
//   play_audio_valid = FIFO non-empty & pause=0 & state not ABORT.
//   Sample selection: half=0 -> head[15:0]; half=1 -> head[31:16] (low half is the earlier sample).
//   A transfer occurs on valid&ready: toggle half; on a half=1 transfer, pop the FIFO.
//   Valid may fall without a transfer only on pause or stop. Data is stable while valid&!ready.
//  Latency: play_read rises 1 cycle after an accepted start.
//    The first sample is valid 1 cycle after the first play_sdram_finished.
//  FIFO: push and pop in the same cycle are both allowed when full or empty-with-push.
//    Occupancy check counts the in-flight read, so no overflow is possible.
//  Address arithmetic is ADDR_W-bit modulo. end < start is a legal wrapping range through 2^ADDR_W-1.
// STRUCTURE
//  audio_pkg: ADDR_W localparam, typedef logic [15:0] sample_t, enum play_state_e.
//  Sub-module play_word_fifo: sync FIFO, 32-bit x FIFO_DEPTH.
//    Ports push/pop/flush/full/empty/count; first-word-fall-through.
//  Top: fetch FSM, address counter, half-select unpacker.
// TESTING
//  1 start=0x100,end=0x104,loop=0, SDRAM latency 3, ready=1
//    -> reads at 0x100..0x103; 8 samples lo/hi ordered; exactly one done pulse after the last sample.
//  2 start=end=0x20 -> no play_read; play_done pulses 1 cycle after start.
//  3 ready held 0 -> 4 reads (FIFO full), then play_read stays 0; data stable with valid=1.
//  4 loop=1,start=0x7FFFFE,end=0x000001 -> address sequence 0x7FFFFE, 0x7FFFFF, 0x000000, 0x7FFFFE...; no done.
//  5 pause asserted during WAIT -> that read completes, then no reads and valid=0.
//    Release -> resumes at the next address with no sample lost or duplicated.
//  6 stop during WAIT with FIFO 2/4 full -> play_read held until finished; FIFO flushed; one done pulse; IDLE.
//    An async i_rst mid-run forces all outputs to 0 immediately.

Source files
------------

// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio playback path: the default SDRAM word
// address width, the 16-bit sample type and the fetch FSM state encoding.
// ---------------------------------------------------------------------------
package audio_pkg;

    // Default SDRAM word-address width.
    localparam int ADDR_W = 23;

    // One audio sample as delivered to the DAC path.
    typedef logic [15:0] sample_t;

    // Fetch FSM states. The values are fixed so the encoding stays stable
    // for anything that inspects the raw state bits.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_ABORT  = 3'd5
    } play_state_e;

endpackage

// File: rtl/play_word_fifo.sv
// ---------------------------------------------------------------------------
// play_word_fifo
// Synchronous first-word-fall-through FIFO holding prefetched SDRAM words.
// The head word is visible on head_o whenever empty_o is low.
// Ports:
//   clk_i, rst_i       clock and asynchronous active-high reset
//   push_i, push_data_i  write a word (accepted when not full, or when a
//                      pop happens in the same cycle)
//   pop_i              drop the head word (ignored when empty)
//   flush_i            discard all contents; wins over push and pop
//   head_o             current head word
//   full_o, empty_o    occupancy flags
//   count_o            number of stored words (0..DEPTH)
// ---------------------------------------------------------------------------
module play_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_eff, push_eff;

    // A pop on an empty FIFO is meaningless; a push into a full FIFO is
    // only safe when the head leaves in the same cycle.
    assign pop_eff  = pop_i && (count_q != '0);
    assign push_eff = push_i && ((count_q != DEPTH_C) || pop_eff);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_eff)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_eff) - CW'(pop_eff);
        end
    end

    // Storage needs no reset: nothing reads a slot before it is written.
    always_ff @(posedge clk_i) begin
        if (push_eff && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/play_core.sv
// ---------------------------------------------------------------------------
// play_core
// Playback engine. Reads 32-bit words from SDRAM over [start, end) (modulo
// 2^ADDR_W), prefetches them into a small FIFO and streams each word as two
// 16-bit samples (low half first) over a valid/ready interface.
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   play_start/_start_addr/_end_addr/_loop   start command and its range
//   play_pause               level; freezes reads and sample output
//   play_stop                pulse; abort playback
//   play_done                pulse when playback ends or is aborted
//   play_read/_addr          SDRAM read request, held until finished
//   play_readdata, play_sdram_finished       SDRAM read completion
//   play_audio_data/_valid/_ready            sample stream to the DAC path
// ---------------------------------------------------------------------------
module play_core #(
    parameter int ADDR_W     = audio_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              play_start,
    input  logic [ADDR_W-1:0] play_start_addr,
    input  logic [ADDR_W-1:0] play_end_addr,
    input  logic              play_loop,
    input  logic              play_pause,
    input  logic              play_stop,
    output logic              play_done,
    output logic              play_read,
    output logic [ADDR_W-1:0] play_addr,
    input  logic [31:0]       play_readdata,
    input  logic              play_sdram_finished,
    output logic [15:0]       play_audio_data,
    output logic              play_audio_valid,
    input  logic              play_audio_ready
);

    import audio_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    play_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] next_cur;
    logic              loop_q, loop_d;
    logic              read_q, read_d;
    logic              done_q, done_d;
    logic              half_q, half_d;

    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       fifo_head;
    logic              audio_fire;
    sample_t           sample;

    play_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .push_i      (fifo_push),
        .push_data_i (play_readdata),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Output side: a word leaves the FIFO only after its high half is sent.
    assign play_audio_valid = !fifo_empty && !play_pause && (state_q != ST_ABORT);
    assign audio_fire       = play_audio_valid && play_audio_ready;
    assign fifo_pop         = audio_fire && half_q;
    assign sample           = half_q ? fifo_head[31:16] : fifo_head[15:0];
    assign play_audio_data  = fifo_empty ? 16'h0000 : sample;

    assign next_cur = cur_q + ADDR_W'(1);

    // Fetch FSM. At most one read is ever outstanding, so checking for a
    // free FIFO slot before issuing reserves room for the in-flight word.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        start_d    = start_q;
        end_d      = end_q;
        loop_d     = loop_q;
        read_d     = read_q;
        addr_d     = addr_q;
        done_d     = 1'b0;
        half_d     = audio_fire ? ~half_q : half_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (play_start) begin
                    start_d = play_start_addr;
                    end_d   = play_end_addr;
                    loop_d  = play_loop;
                    cur_d   = play_start_addr;
                    if (play_start_addr == play_end_addr) begin
                        done_d = 1'b1;
                    end else if (play_pause) begin
                        state_d = ST_REQ;
                    end else begin
                        // Issue the first read straight away so it appears
                        // one cycle after the start pulse.
                        read_d  = 1'b1;
                        addr_d  = play_start_addr;
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_REQ: begin
                if (play_stop) begin
                    state_d = ST_ABORT;
                end else if (play_pause) begin
                    state_d = ST_PAUSED;
                end else if (!fifo_full) begin
                    read_d  = 1'b1;
                    addr_d  = cur_q;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (play_sdram_finished) begin
                    read_d = 1'b0;
                    if (play_stop) begin
                        state_d = ST_ABORT;
                    end else begin
                        fifo_push = 1'b1;
                        if (next_cur == end_q) begin
                            cur_d   = loop_q ? start_q : next_cur;
                            state_d = loop_q ? ST_REQ : ST_DRAIN;
                        end else begin
                            cur_d   = next_cur;
                            state_d = ST_REQ;
                        end
                    end
                end else if (play_stop) begin
                    state_d = ST_ABORT;
                end
            end

            ST_PAUSED: begin
                if (play_stop) begin
                    state_d = ST_ABORT;
                end else if (!play_pause) begin
                    state_d = ST_REQ;
                end
            end

            ST_DRAIN: begin
                if (play_stop) begin
                    state_d = ST_ABORT;
                end else if (fifo_count == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_ABORT: begin
                // An outstanding read must still complete on the SDRAM side;
                // its data is simply never pushed.
                if (!read_q || play_sdram_finished) begin
                    read_d     = 1'b0;
                    fifo_flush = 1'b1;
                    half_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces every output low at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            start_q <= '0;
            end_q   <= '0;
            loop_q  <= 1'b0;
            read_q  <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            start_q <= start_d;
            end_q   <= end_d;
            loop_q  <= loop_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            half_q  <= half_d;
        end
    end

    assign play_read = read_q;
    assign play_addr = addr_q;
    assign play_done = done_q;

endmodule

// File: tb/tb_play_core.sv
// ---------------------------------------------------------------------------
// tb_play_core
// Self-checking bench for play_core. An SDRAM responder model answers reads
// with an address-derived word and checks request addresses against the
// expected range walk; a monitor pops expected samples whenever a sample is
// transferred and checks done pulses and data stability.
// ---------------------------------------------------------------------------
module tb_play_core;

    logic        clk, rst;
    logic        playStart, playLoop, playPause, playStop;
    logic [22:0] playStartAddr, playEndAddr;
    logic        playDone, playRead;
    logic [22:0] playAddr;
    logic [31:0] playReaddata;
    logic        playSdramFinished;
    logic [15:0] playAudioData;
    logic        playAudioValid, playAudioReady;

    int          checks = 0;
    int          errors = 0;
    int          readsIssued = 0;
    int          doneCount = 0;
    int          latCfg = 3;
    bit          randReady = 0;
    bit          expectEmptyAtDone = 1;
    logic [22:0] expAddrQ[$];
    logic [15:0] expSampleQ[$];

    int          d0, r0, rlen;
    bit          sawValid;
    logic [22:0] rs, re;

    play_core #(
        .ADDR_W     (23),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .play_start          (playStart),
        .play_start_addr     (playStartAddr),
        .play_end_addr       (playEndAddr),
        .play_loop           (playLoop),
        .play_pause          (playPause),
        .play_stop           (playStop),
        .play_done           (playDone),
        .play_read           (playRead),
        .play_addr           (playAddr),
        .play_readdata       (playReaddata),
        .play_sdram_finished (playSdramFinished),
        .play_audio_data     (playAudioData),
        .play_audio_valid    (playAudioValid),
        .play_audio_ready    (playAudioReady)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Contents the SDRAM model returns for each word address.
    function automatic logic [31:0] wordAt(input logic [22:0] a);
        logic [15:0] lo, hi;
        lo = a[15:0] ^ {9'h05A, a[22:16]};
        hi = ~a[15:0] + {a[22:16], 9'h0C3};
        return {hi, lo};
    endfunction

    // Expected playback of nWords words: the range walked modulo its length,
    // each word contributing its low then high sample.
    task automatic queuePlayback(input logic [22:0] s, input logic [22:0] e, input int nWords);
        logic [22:0] len, a;
        logic [31:0] w;
        len = e - s;
        for (int i = 0; i < nWords; i++) begin
            a = s + 23'(i % int'(len));
            w = wordAt(a);
            expAddrQ.push_back(a);
            expSampleQ.push_back(w[15:0]);
            expSampleQ.push_back(w[31:16]);
        end
    endtask

    // Issue one start pulse; returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [22:0] s, input logic [22:0] e, input logic lp);
        @(posedge clk); #1;
        playStartAddr = s;
        playEndAddr   = e;
        playLoop      = lp;
        playStart     = 1'b1;
        @(posedge clk); #1;
        playStart     = 1'b0;
    endtask

    task automatic pulseStop();
        @(posedge clk); #1 playStop = 1'b1;
        @(posedge clk); #1 playStop = 1'b0;
    endtask

    task automatic waitDone(input int target, input int bound);
        for (int i = 0; i < bound && doneCount < target; i++) @(negedge clk);
        checkOutput("doneReached", doneCount, target);
    endtask

    task automatic waitReads(input int target, input int bound);
        for (int i = 0; i < bound && !((readsIssued - r0) >= target && playRead); i++) @(negedge clk);
        checkOutput("readsReached", (readsIssued - r0) >= target, 1);
    endtask

    // SDRAM responder: checks each request address, holds for a latency,
    // then completes with the modelled word and checks the 1-cycle gap.
    initial begin
        logic [22:0] a;
        int lat;
        playSdramFinished = 1'b0;
        playReaddata      = '0;
        forever begin
            @(negedge clk);
            if (playRead === 1'b1 && !rst) begin
                a = playAddr;
                readsIssued++;
                if (expAddrQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedRead actual=0x%0h required=none", a);
                end else begin
                    checkOutput("readAddr", a, expAddrQ.pop_front());
                end
                lat = (latCfg == 0) ? $urandom_range(1, 4) : latCfg;
                for (int k = 1; k < lat; k++) begin
                    @(negedge clk);
                    checkOutput("readHeld", {playRead, playAddr}, {1'b1, a});
                end
                playReaddata      = wordAt(a);
                playSdramFinished = 1'b1;
                @(negedge clk);
                playSdramFinished = 1'b0;
                playReaddata      = '0;
                checkOutput("readGap", playRead, 1'b0);
            end
        end
    end

    // Randomized sink back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (randReady) playAudioReady = 1'($urandom_range(0, 1));
        end
    end

    // Sample monitor and done counter.
    initial begin
        bit          prevVnr;
        logic [15:0] prevData;
        prevVnr  = 1'b0;
        prevData = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevVnr = 1'b0;
            end else begin
                if (prevVnr && playAudioValid) checkOutput("dataStable", playAudioData, prevData);
                if (playAudioValid && playAudioReady) begin
                    if (expSampleQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpectedSample actual=0x%0h required=none", playAudioData);
                    end else begin
                        checkOutput("sample", playAudioData, expSampleQ.pop_front());
                    end
                end
                prevVnr  = playAudioValid && !playAudioReady;
                prevData = playAudioData;
                if (playDone) begin
                    doneCount++;
                    if (expectEmptyAtDone) checkOutput("doneAfterLast", expSampleQ.size(), 0);
                end
            end
        end
    end

    // Directed scenarios with randomized latency, back-pressure and ranges.
    initial begin
        rst = 1'b1;
        playStart = 0; playLoop = 0; playPause = 0; playStop = 0;
        playStartAddr = '0; playEndAddr = '0; playAudioReady = 1'b1;

        #12;
        checkOutput("resetCtl", {playRead, playDone, playAudioValid}, 3'b000);
        checkOutput("resetAddr", playAddr, 0);
        checkOutput("resetData", playAudioData, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic four-word playback, fixed latency, sink always ready.
        latCfg = 3;
        d0 = doneCount;
        queuePlayback(23'h100, 23'h104, 4);
        applyStimulus(23'h100, 23'h104, 1'b0);
        @(negedge clk);
        checkOutput("startLatency", playRead, 1'b1);
        waitDone(d0 + 1, 300);
        repeat (5) @(negedge clk);
        checkOutput("s1DoneOnce", doneCount, d0 + 1);
        checkOutput("s1SamplesLeft", expSampleQ.size(), 0);
        checkOutput("s1AddrsLeft", expAddrQ.size(), 0);

        // Empty range: immediate done, no read.
        d0 = doneCount;
        r0 = readsIssued;
        applyStimulus(23'h20, 23'h20, 1'b0);
        @(negedge clk);
        checkOutput("emptyDone", playDone, 1'b1);
        checkOutput("emptyNoRead", playRead, 1'b0);
        @(negedge clk);
        checkOutput("emptyDonePulse", playDone, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("emptyDoneOnce", doneCount, d0 + 1);
        checkOutput("emptyReads", readsIssued - r0, 0);

        // Sink stalled: prefetch fills the FIFO then stops; then async reset.
        latCfg = 0;
        playAudioReady = 1'b0;
        r0 = readsIssued;
        queuePlayback(23'h200, 23'h210, 16);
        applyStimulus(23'h200, 23'h210, 1'b0);
        repeat (60) @(negedge clk);
        checkOutput("fullReads", readsIssued - r0, 4);
        checkOutput("fullReadIdle", playRead, 1'b0);
        checkOutput("fullValid", playAudioValid, 1'b1);
        checkOutput("fullHead", playAudioData, expSampleQ[0]);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRstCtl", {playRead, playDone, playAudioValid}, 3'b000);
        checkOutput("asyncRstAddr", playAddr, 0);
        checkOutput("asyncRstData", playAudioData, 0);
        expAddrQ.delete();
        expSampleQ.delete();
        @(posedge clk); #1 rst = 1'b0;

        // Looping range that wraps through the top of the address space.
        randReady = 1;
        d0 = doneCount;
        r0 = readsIssued;
        queuePlayback(23'h7FFFFE, 23'h000001, 40);
        applyStimulus(23'h7FFFFE, 23'h000001, 1'b1);
        waitReads(10, 600);
        checkOutput("loopNoDone", doneCount, d0);
        expectEmptyAtDone = 0;
        pulseStop();
        waitDone(d0 + 1, 100);
        randReady = 0;
        playAudioReady = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("loopStopDoneOnce", doneCount, d0 + 1);
        expAddrQ.delete();
        expSampleQ.delete();
        expectEmptyAtDone = 1;

        // Pause while a read is outstanding, then resume.
        latCfg = 4;
        d0 = doneCount;
        r0 = readsIssued;
        queuePlayback(23'h300, 23'h308, 8);
        applyStimulus(23'h300, 23'h308, 1'b0);
        waitReads(3, 200);
        @(posedge clk); #1 playPause = 1'b1;
        sawValid = 0;
        repeat (30) begin
            @(negedge clk);
            sawValid |= playAudioValid;
        end
        checkOutput("pauseNoValid", sawValid, 1'b0);
        checkOutput("pauseReads", readsIssued - r0, 3);
        checkOutput("pauseReadIdle", playRead, 1'b0);
        @(posedge clk); #1 playPause = 1'b0;
        waitDone(d0 + 1, 300);
        checkOutput("pauseSamplesLeft", expSampleQ.size(), 0);

        // Stop while a read is outstanding and two words are buffered.
        playAudioReady = 1'b0;
        d0 = doneCount;
        r0 = readsIssued;
        queuePlayback(23'h400, 23'h410, 16);
        applyStimulus(23'h400, 23'h410, 1'b0);
        waitReads(3, 200);
        expectEmptyAtDone = 0;
        pulseStop();
        @(negedge clk);
        checkOutput("abortReadHeld", playRead, 1'b1);
        waitDone(d0 + 1, 100);
        repeat (5) @(negedge clk);
        checkOutput("abortDoneOnce", doneCount, d0 + 1);
        checkOutput("abortFlushed", playAudioValid, 1'b0);
        checkOutput("abortReadIdle", playRead, 1'b0);
        expAddrQ.delete();
        expSampleQ.delete();
        expectEmptyAtDone = 1;

        // Random short ranges; stale words after the abort would show here.
        latCfg = 0;
        randReady = 1;
        for (int n = 0; n < 3; n++) begin
            rs   = 23'($urandom);
            rlen = $urandom_range(1, 6);
            re   = rs + 23'(rlen);
            d0   = doneCount;
            queuePlayback(rs, re, rlen);
            applyStimulus(rs, re, 1'b0);
            waitDone(d0 + 1, 400);
            checkOutput("randSamplesLeft", expSampleQ.size(), 0);
            checkOutput("randAddrsLeft", expAddrQ.size(), 0);
        end
        randReady = 0;

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
